uart_tx_buffer: RTL and testbench
=================================

# uart_tx_buffer

Byte FIFO and transmit sequencer that sits directly upstream of `uart_send`. Producers (command responder, camera status/pixel dumpers) push bytes at full clock rate; the block holds up to `DEPTH` bytes and hands them one at a time to `uart_send` over its `DATA`/`DATA_READY`/`IDLE` handshake. It replaces per-producer pacing logic built around polling `IDLE`.

## Interface
- `DEPTH`, 16: FIFO capacity in bytes; power of two, 2..256.
- `GUARD`, 4: max cycles to wait for `TX_IDLE` to fall after a `TX_DATA_READY` pulse; 1..15.

- `CLK` in 1: single clock, all logic on rising edge.
- `RST_N` in 1: reset, asynchronous assert, active-low.
- `WR_DATA` in 8: byte to enqueue.
- `WR_EN` in 1: enqueue strobe, one byte per cycle high.
- `FULL` out 1: FIFO holds `DEPTH` bytes.
- `EMPTY` out 1: FIFO holds 0 bytes.
- `COUNT` out log2(DEPTH)+1: bytes currently stored.
- `OVERFLOW` out 1: sticky; set by a write while `FULL`.
- `OVF_CLR` in 1: clears `OVERFLOW`.
- `TX_DATA` out 8: to `uart_send.DATA`.
- `TX_DATA_READY` out 1: to `uart_send.DATA_READY`; one-cycle pulse.
- `TX_IDLE` in 1: from `uart_send.IDLE`.
- `BUSY` out 1: high when FIFO non-empty or FSM not in `S_IDLE`.

## Operation
- Reset (`RST_N` low): FIFO pointers and `COUNT` 0, `EMPTY` 1, `FULL` 0, `OVERFLOW` 0, `TX_DATA` 8'h00, `TX_DATA_READY` 0, `BUSY` 0, FSM `S_IDLE`. Reset mid-transfer drops all stored bytes; in-flight `uart_send` frame is not this block's concern.
- Write: `WR_EN` && !`FULL` stores `WR_DATA` at write pointer. `WR_EN` && `FULL` discards byte, sets `OVERFLOW`; nothing else changes — even if a pop occurs the same cycle (`FULL` is the registered value).
- `OVF_CLR` and overflowing write same cycle: `OVERFLOW` stays 1 (set wins).
- Pointers are `log2(DEPTH)` bits and wrap naturally; `COUNT` = writes accepted − pops, never exceeds `DEPTH`.
- Simultaneous accepted write and pop: `COUNT` unchanged, both pointers advance.
- FSM:
  - `S_IDLE`: if !`EMPTY` && `TX_IDLE`: pop head, register it onto `TX_DATA`, pulse `TX_DATA_READY`, go `S_WAIT_BUSY`.
  - `S_WAIT_BUSY`: wait for `TX_IDLE`=0 → `S_WAIT_DONE`. If `GUARD` cycles elapse with `TX_IDLE` still 1, treat byte as taken and go `S_IDLE` (guard counter reset on entry).
  - `S_WAIT_DONE`: wait for `TX_IDLE`=1 → `S_IDLE`.
- `TX_DATA` holds the last popped byte until the next pop.
- Bytes leave in exact write order; none duplicated or skipped except overflow discards.

## Timing
- All outputs registered.
- Write at edge k into empty FIFO with FSM in `S_IDLE` and `TX_IDLE`=1: `EMPTY` falls after edge k; `TX_DATA`/`TX_DATA_READY` valid after edge k+1; `TX_DATA_READY` low again after edge k+2.
- Minimum byte-to-byte spacing: 1 cycle `S_IDLE` + ≥1 cycle `S_WAIT_BUSY` + `S_WAIT_DONE` duration; back-to-back `TX_DATA_READY` pulses never closer than 3 cycles.
- `FULL`/`EMPTY`/`COUNT` update the edge after the causing write/pop.

## Structure
- Shared package `uart_pkg`: FSM state enum (`S_IDLE`, `S_WAIT_BUSY`, `S_WAIT_DONE`), default `GUARD`, byte width constant 8.
- Sub-module `byte_fifo` (parameter `DEPTH`): storage, pointers, `COUNT`, `FULL`/`EMPTY`, `OVERFLOW`. Top of `uart_tx_buffer` holds the FSM and guard counter.

## Test plan
- Reset: hold `RST_N` low mid-stream → all outputs at reset values immediately (asynchronous), `COUNT`=0 after release, no `TX_DATA_READY`.
- Ordering: write "0".."9" back-to-back with `uart_send` model (IDLE low 2 cycles after pulse, busy 20 cycles) → `TX_DATA` sequence 8'h30..8'h39, exactly 10 pulses.
- Full/overflow, `DEPTH`=16, `TX_IDLE` held 0: write 17 bytes → `FULL`=1 after 16th, `COUNT`=16, `OVERFLOW`=1, 17th byte never transmitted; `OVF_CLR` pulse → `OVERFLOW`=0.
- Simultaneous: FIFO holding 3 bytes, write coinciding with pop → `COUNT` stays 3, order preserved.
- Guard: `TX_IDLE` stuck 1 → pulses spaced `GUARD`+2 cycles, all bytes drained once each.
- Wrap: write/drain 40 bytes 0x00..0x27 with `DEPTH`=16 → output identical sequence, `EMPTY`=1 at end.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Holds the sequencer state encoding and byte width.
package uart_pkg;

  localparam int BYTE_W    = 8;
  localparam int GUARD_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with registered FULL/EMPTY/COUNT.
// A write while full is dropped and latches OVERFLOW.
module byte_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [BYTE_W-1:0] WR_DATA,
  input  logic              WR_EN,
  input  logic              RD_EN,
  output logic [BYTE_W-1:0] RD_DATA,
  output logic              FULL,
  output logic              EMPTY,
  output logic              EMPTY_NXT,
  output logic [AW:0]       COUNT,
  output logic              OVERFLOW,
  input  logic              OVF_CLR
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              ovf_q, ovf_d;
  logic              push, pop;

  // Pointer, occupancy and sticky-overflow next state.
  always_comb begin
    push    = WR_EN && !full_q;
    pop     = RD_EN && !empty_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
    full_d  = (cnt_d == CNT_FULL);
    empty_d = (cnt_d == '0);
    if (WR_EN && full_q) ovf_d = 1'b1;
    else if (OVF_CLR)    ovf_d = 1'b0;
  end

  // Control state registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= WR_DATA;
  end

  assign RD_DATA   = mem_q[rptr_q];
  assign FULL      = full_q;
  assign EMPTY     = empty_q;
  assign EMPTY_NXT = empty_d;
  assign COUNT     = cnt_q;
  assign OVERFLOW  = ovf_q;

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffered byte feeder for uart_send.
// Pops one byte per uart_send frame with a stuck-IDLE guard.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int GUARD = GUARD_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [BYTE_W-1:0] WR_DATA,
  input  logic              WR_EN,
  output logic              FULL,
  output logic              EMPTY,
  output logic [AW:0]       COUNT,
  output logic              OVERFLOW,
  input  logic              OVF_CLR,
  output logic [BYTE_W-1:0] TX_DATA,
  output logic              TX_DATA_READY,
  input  logic              TX_IDLE,
  output logic              BUSY
);

  localparam logic [3:0] GUARD_LIM = 4'(GUARD);

  tx_state_e         state_q, state_d;
  logic [3:0]        guard_q, guard_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              tx_rdy_q, tx_rdy_d;
  logic              busy_q, busy_d;
  logic              pop;
  logic [BYTE_W-1:0] head;
  logic              empty_nxt;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .WR_DATA   (WR_DATA),
    .WR_EN     (WR_EN),
    .RD_EN     (pop),
    .RD_DATA   (head),
    .FULL      (FULL),
    .EMPTY     (EMPTY),
    .EMPTY_NXT (empty_nxt),
    .COUNT     (COUNT),
    .OVERFLOW  (OVERFLOW),
    .OVF_CLR   (OVF_CLR)
  );

  // Sequencer: pop, wait for uart_send to go busy, wait for done.
  always_comb begin
    state_d   = state_q;
    guard_d   = guard_q;
    tx_data_d = tx_data_q;
    tx_rdy_d  = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!EMPTY && TX_IDLE) begin
          pop       = 1'b1;
          tx_data_d = head;
          tx_rdy_d  = 1'b1;
          guard_d   = '0;
          state_d   = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (!TX_IDLE)                 state_d = S_WAIT_DONE;
        else if (guard_q == GUARD_LIM) state_d = S_IDLE;
        else                          guard_d = guard_q + 4'd1;
      end
      S_WAIT_DONE: begin
        if (TX_IDLE) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = !empty_nxt || (state_d != S_IDLE);
  end

  // Sequencer and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      guard_q   <= '0;
      tx_data_q <= '0;
      tx_rdy_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      guard_q   <= guard_d;
      tx_data_q <= tx_data_d;
      tx_rdy_q  <= tx_rdy_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_DATA       = tx_data_q;
  assign TX_DATA_READY = tx_rdy_q;
  assign BUSY          = busy_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Bench for uart_tx_buffer: queue scoreboard plus
// a simple uart_send model and directed phases.
module tb_uart_tx_buffer;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int GUARD = 4;
  localparam int AW    = 4;

  logic        CLK = 0;
  logic        RST_N = 0;
  logic [7:0]  WR_DATA = 0;
  logic        WR_EN = 0;
  logic        OVF_CLR = 0;
  logic        TX_IDLE = 1;
  logic        FULL, EMPTY, OVERFLOW;
  logic        TX_DATA_READY, BUSY;
  logic [AW:0] COUNT;
  logic [7:0]  TX_DATA;

  int checks = 0;
  int errors = 0;
  byte unsigned mq[$];
  bit  m_ovf = 0;
  int  pulses = 0;
  int  cyc = 0;
  int  last_pulse = -1;
  bit  guard_phase = 0;
  bit  guard_prev = 0;
  int  umode = 2;
  int  u_cnt = 0;

  uart_tx_buffer #(.DEPTH(DEPTH), .GUARD(GUARD)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .WR_DATA       (WR_DATA),
    .WR_EN         (WR_EN),
    .FULL          (FULL),
    .EMPTY         (EMPTY),
    .COUNT         (COUNT),
    .OVERFLOW      (OVERFLOW),
    .OVF_CLR       (OVF_CLR),
    .TX_DATA       (TX_DATA),
    .TX_DATA_READY (TX_DATA_READY),
    .TX_IDLE       (TX_IDLE),
    .BUSY          (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // uart_send model: 1 = IDLE stuck low, 2 = stuck high,
  // 0 = IDLE falls ~2 cycles after a pulse, low 20 cycles.
  always begin
    @(negedge CLK);
    #2;
    case (umode)
      1: begin TX_IDLE = 0; u_cnt = 0; end
      2: begin TX_IDLE = 1; u_cnt = 0; end
      default: begin
        if (TX_DATA_READY) u_cnt = 22;
        if (u_cnt > 0) u_cnt--;
        TX_IDLE = !(u_cnt > 0 && u_cnt <= 20);
      end
    endcase
  end

  // Scoreboard: queue of accepted bytes, compared every cycle.
  always @(posedge CLK) begin
    bit wr, clr, fullpre;
    byte unsigned d;
    wr = WR_EN;
    d = WR_DATA;
    clr = OVF_CLR;
    fullpre = (mq.size() == DEPTH);
    cyc++;
    #1;
    if (!RST_N) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      if (TX_DATA_READY) begin
        pulses++;
        if (mq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_empty: got byte %0h expected none", TX_DATA);
        end else begin
          chk("tx_data", TX_DATA, mq.pop_front());
        end
        if (last_pulse >= 0)
          chk("pulse_gap_min", (cyc - last_pulse >= 3), 1);
        if (guard_phase && guard_prev)
          chk("guard_gap", cyc - last_pulse, GUARD + 2);
        guard_prev = guard_phase;
        last_pulse = cyc;
      end
      if (wr && !fullpre) mq.push_back(d);
      if (wr && fullpre) m_ovf = 1;
      else if (clr)      m_ovf = 0;
      chk("count", COUNT, mq.size());
      chk("full", FULL, mq.size() == DEPTH);
      chk("empty", EMPTY, mq.size() == 0);
      chk("overflow", OVERFLOW, m_ovf);
    end
  end

  task automatic wait_idle(int maxc, string nm);
    int n = 0;
    while (!(mq.size() == 0 && BUSY == 0 && EMPTY == 1) && n < maxc) begin
      @(negedge CLK);
      n++;
    end
    chk({nm, "_drain_in_time"}, (n < maxc), 1);
  endtask

  task automatic chk_reset_vals(string nm);
    chk({nm, "_count"}, COUNT, 0);
    chk({nm, "_empty"}, EMPTY, 1);
    chk({nm, "_full"}, FULL, 0);
    chk({nm, "_ovf"}, OVERFLOW, 0);
    chk({nm, "_txdata"}, TX_DATA, 0);
    chk({nm, "_txrdy"}, TX_DATA_READY, 0);
    chk({nm, "_busy"}, BUSY, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk_reset_vals("rst");
    @(negedge CLK) RST_N = 1;

    // Ordering "0".."9" with latency pins
    umode = 0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      WR_EN = 1;
      WR_DATA = 8'h30 + 8'(i);
      @(posedge CLK);
      #1;
      if (i == 0) begin
        chk("lat_empty", EMPTY, 0);
        chk("lat_count", COUNT, 1);
        chk("lat_rdy0", TX_DATA_READY, 0);
      end
      if (i == 1) begin
        chk("lat_rdy1", TX_DATA_READY, 1);
        chk("lat_data", TX_DATA, 8'h30);
      end
      if (i == 2) begin
        chk("lat_rdy2", TX_DATA_READY, 0);
        chk("lat_busy", BUSY, 1);
      end
    end
    @(negedge CLK) WR_EN = 0;
    wait_idle(400, "order");
    chk("order_pulses", pulses, 10);
    chk("order_last", TX_DATA, 8'h39);

    // Full / overflow with TX_IDLE low
    @(negedge CLK) umode = 1;
    repeat (3) @(negedge CLK);
    pulses = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge CLK);
      WR_EN = 1;
      WR_DATA = 8'hA0 + 8'(i);
      @(posedge CLK);
      #1;
      if (i == 15) begin
        chk("full_16", FULL, 1);
        chk("count_16", COUNT, 16);
        chk("ovf_16", OVERFLOW, 0);
      end
      if (i == 16) begin
        chk("ovf_17", OVERFLOW, 1);
        chk("count_17", COUNT, 16);
      end
    end
    @(negedge CLK);
    WR_EN = 0;
    OVF_CLR = 1;
    @(posedge CLK);
    #1;
    chk("ovf_clr", OVERFLOW, 0);
    @(negedge CLK);
    WR_EN = 1;
    WR_DATA = 8'hEE;
    @(posedge CLK);
    #1;
    chk("ovf_set_wins", OVERFLOW, 1);
    @(negedge CLK) WR_EN = 0;
    @(negedge CLK) OVF_CLR = 0;
    chk("ovf_clr2", OVERFLOW, 0);
    umode = 0;
    wait_idle(16 * 25 + 50, "full");
    chk("full_pulses", pulses, 16);
    chk("full_last", TX_DATA, 8'hAF);

    // Simultaneous write and pop with 3 stored
    @(negedge CLK) umode = 1;
    repeat (3) @(negedge CLK);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      WR_EN = 1;
      WR_DATA = 8'hC0 + 8'(i);
      @(negedge CLK);
    end
    WR_EN = 0;
    repeat (2) @(negedge CLK);
    chk("sim_pre", COUNT, 3);
    umode = 2;
    WR_EN = 1;
    WR_DATA = 8'hC3;
    @(posedge CLK);
    #1;
    chk("sim_count", COUNT, 3);
    chk("sim_rdy", TX_DATA_READY, 1);
    chk("sim_data", TX_DATA, 8'hC0);
    @(negedge CLK);
    WR_EN = 0;
    umode = 0;
    wait_idle(200, "sim");
    chk("sim_pulses", pulses, 4);

    // Guard timeout with TX_IDLE stuck high
    @(negedge CLK) umode = 2;
    repeat (3) @(negedge CLK);
    pulses = 0;
    guard_phase = 1;
    guard_prev = 0;
    for (int i = 0; i < 5; i++) begin
      WR_EN = 1;
      WR_DATA = 8'h50 + 8'(i);
      @(negedge CLK);
    end
    WR_EN = 0;
    wait_idle(100, "guard");
    guard_phase = 0;
    chk("guard_pulses", pulses, 5);

    // Wrap: 40 bytes through 16 entries
    @(negedge CLK) umode = 0;
    pulses = 0;
    begin
      int i = 0;
      int n = 0;
      while (i < 40 && n < 5000) begin
        @(negedge CLK);
        n++;
        if (!FULL) begin
          WR_EN = 1;
          WR_DATA = 8'(i);
          i++;
        end else begin
          WR_EN = 0;
        end
      end
      chk("wrap_written", i, 40);
    end
    @(negedge CLK) WR_EN = 0;
    wait_idle(800, "wrap");
    chk("wrap_pulses", pulses, 40);
    chk("wrap_empty", EMPTY, 1);
    chk("wrap_last", TX_DATA, 8'h27);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      WR_EN = 1;
      WR_DATA = 8'h60 + 8'(i);
    end
    @(negedge CLK) WR_EN = 0;
    repeat (4) @(negedge CLK);
    chk("pre_rst_busy", BUSY, 1);
    @(posedge CLK);
    #2;
    RST_N = 0;
    #1;
    chk_reset_vals("arst");
    repeat (3) @(negedge CLK);
    RST_N = 1;
    pulses = 0;
    repeat (30) @(negedge CLK);
    chk("post_rst_pulses", pulses, 0);
    chk("post_rst_count", COUNT, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
